// File: rtl/vlc_sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read,
// level flags derived from a registered word count and sticky error flags.
module vlc_sync_fifo #(
  parameter int F_WIDTH              = 32,
  parameter int F_PTR_WIDTH          = 10,
  parameter int F_ALMOST_FULL_VALUE  = 1000,
  parameter int F_ALMOST_EMPTY_VALUE = 5,
  parameter int F_FWFT               = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [F_WIDTH-1:0]   d_in,
  input  logic                 w_en,
  input  logic                 r_en,
  input  logic                 clr_err,
  output logic [F_WIDTH-1:0]   d_out,
  output logic                 d_valid,
  output logic                 f_full_flag,
  output logic                 f_empty_flag,
  output logic                 f_half_full_flag,
  output logic                 f_almost_full_flag,
  output logic                 f_almost_empty_flag,
  output logic [F_PTR_WIDTH:0] data_num,
  output logic                 f_overflow,
  output logic                 f_underflow
);

  localparam int F_DEPTH = 2 ** F_PTR_WIDTH;

  localparam logic [F_PTR_WIDTH:0] DEPTH_C =
    {1'b1, {F_PTR_WIDTH{1'b0}}};
  localparam logic [F_PTR_WIDTH:0] HALF_C =
    {2'b01, {(F_PTR_WIDTH-1){1'b0}}};
  localparam logic [F_PTR_WIDTH:0] AF_C =
    F_ALMOST_FULL_VALUE[F_PTR_WIDTH:0];
  localparam logic [F_PTR_WIDTH:0] AE_C =
    F_ALMOST_EMPTY_VALUE[F_PTR_WIDTH:0];

  logic [F_WIDTH-1:0]   mem [F_DEPTH];
  logic [F_PTR_WIDTH:0] wr_ptr;
  logic [F_PTR_WIDTH:0] rd_ptr;
  logic [F_PTR_WIDTH:0] cnt_nx;
  logic                 wr_acc;
  logic                 rd_acc;

  logic [F_PTR_WIDTH-1:0] wr_addr;
  logic [F_PTR_WIDTH-1:0] rd_addr;

  assign wr_addr = wr_ptr[F_PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr[F_PTR_WIDTH-1:0];

  // Acceptance uses pre-edge flags only: a write at full is
  // refused even if a read frees a slot in the same cycle.
  assign wr_acc = w_en && !f_full_flag;
  assign rd_acc = r_en && !f_empty_flag;

  assign f_full_flag         = (data_num == DEPTH_C);
  assign f_empty_flag        = (data_num == '0);
  assign f_half_full_flag    = (data_num >= HALF_C);
  assign f_almost_full_flag  = (data_num >= AF_C);
  assign f_almost_empty_flag = (data_num <= AE_C);

  always_comb begin
    cnt_nx = data_num;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_nx = data_num + 1'b1;
      2'b01:   cnt_nx = data_num - 1'b1;
      default: cnt_nx = data_num;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_addr] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_num <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      data_num <= cnt_nx;
    end
  end

  // Setting an error wins over clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_overflow  <= 1'b0;
      f_underflow <= 1'b0;
    end else begin
      if (w_en && f_full_flag) f_overflow <= 1'b1;
      else if (clr_err)        f_overflow <= 1'b0;
      if (r_en && f_empty_flag) f_underflow <= 1'b1;
      else if (clr_err)         f_underflow <= 1'b0;
    end
  end

  if (F_FWFT != 0) begin : g_fwft
    assign d_out   = mem[rd_addr];
    assign d_valid = !f_empty_flag;
  end else begin : g_reg
    logic [F_WIDTH-1:0] dq;
    logic               vq;

    always_ff @(posedge clk) begin
      if (reset) begin
        dq <= '0;
        vq <= 1'b0;
      end else begin
        vq <= rd_acc;
        if (rd_acc) dq <= mem[rd_addr];
      end
    end

    assign d_out   = dq;
    assign d_valid = vq;
  end

endmodule

// File: tb/tb_vlc_sync_fifo.sv
// Scoreboard bench: registered-read FIFO against a queue model,
// plus a directed first-word-fall-through instance.
module tb_vlc_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_d;
  logic       a_w, a_r, a_c;
  logic [7:0] a_q;
  logic       a_v, a_full, a_empty, a_half, a_af, a_ae;
  logic [4:0] a_num;
  logic       a_ovf, a_unf;

  logic [7:0] b_d;
  logic       b_w, b_r;
  logic [7:0] b_q;
  logic       b_v, b_full, b_empty, b_half, b_af, b_ae;
  logic [4:0] b_num;
  logic       b_ovf, b_unf;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];
  int         mcnt;
  logic [7:0] last_out;
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  vlc_sync_fifo #(
    .F_WIDTH(8), .F_PTR_WIDTH(4),
    .F_ALMOST_FULL_VALUE(14), .F_ALMOST_EMPTY_VALUE(2),
    .F_FWFT(0)
  ) u_reg (
    .clk(clk), .reset(rst), .d_in(a_d), .w_en(a_w),
    .r_en(a_r), .clr_err(a_c), .d_out(a_q), .d_valid(a_v),
    .f_full_flag(a_full), .f_empty_flag(a_empty),
    .f_half_full_flag(a_half), .f_almost_full_flag(a_af),
    .f_almost_empty_flag(a_ae), .data_num(a_num),
    .f_overflow(a_ovf), .f_underflow(a_unf)
  );

  vlc_sync_fifo #(
    .F_WIDTH(8), .F_PTR_WIDTH(4),
    .F_ALMOST_FULL_VALUE(14), .F_ALMOST_EMPTY_VALUE(2),
    .F_FWFT(1)
  ) u_fwft (
    .clk(clk), .reset(rst), .d_in(b_d), .w_en(b_w),
    .r_en(b_r), .clr_err(1'b0), .d_out(b_q), .d_valid(b_v),
    .f_full_flag(b_full), .f_empty_flag(b_empty),
    .f_half_full_flag(b_half), .f_almost_full_flag(b_af),
    .f_almost_empty_flag(b_ae), .data_num(b_num),
    .f_overflow(b_ovf), .f_underflow(b_unf)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // One clock of the registered instance, checked against the model.
  task automatic step(input logic rs, input logic w,
                      input logic [7:0] d, input logic r,
                      input logic c);
    logic       wa, ra, full_m, empty_m;
    logic [7:0] exp_q;
    full_m  = (mcnt == 16);
    empty_m = (mcnt == 0);
    wa = w && !full_m;
    ra = r && !empty_m;
    exp_q = last_out;
    rst = rs; a_w = w; a_d = d; a_r = r; a_c = c;
    @(posedge clk);
    #1;
    if (rs) begin
      sb.delete();
      mcnt = 0; last_out = 8'h00;
      m_ovf = 1'b0; m_unf = 1'b0;
      ra = 1'b0;
    end else begin
      if (ra) begin
        exp_q = sb.pop_front();
        last_out = exp_q;
        mcnt--;
      end
      if (wa) begin
        sb.push_back(d);
        mcnt++;
      end
      m_ovf = (w && full_m) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && empty_m) ? 1'b1 : (c ? 1'b0 : m_unf);
    end
    check("data_num", a_num, mcnt);
    check("d_valid", a_v, ra);
    check("d_out", a_q, last_out);
    check("full", a_full, mcnt == 16);
    check("empty", a_empty, mcnt == 0);
    check("half", a_half, mcnt >= 8);
    check("afull", a_af, mcnt >= 14);
    check("aempty", a_ae, mcnt <= 2);
    check("overflow", a_ovf, m_ovf);
    check("underflow", a_unf, m_unf);
  endtask

  initial begin
    rst = 1'b1;
    a_d = '0; a_w = 0; a_r = 0; a_c = 0;
    b_d = '0; b_w = 0; b_r = 0;
    mcnt = 0; last_out = '0; m_ovf = 0; m_unf = 0;

    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    check("b_rst_valid", b_v, 1'b0);
    check("b_rst_empty", b_empty, 1'b1);

    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, 0);
    check("last_word", a_q, 8'h0F);
    step(0, 0, 8'h00, 1, 0);
    check("hold_0f", a_q, 8'h0F);
    step(0, 0, 8'h00, 0, 1);

    for (int i = 0; i < 5; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 8'h40 + 8'(i), 1, 0);
    check("steady_num", a_num, 5'd5);

    for (int i = 0; i < 11; i++) step(0, 1, 8'h90 + 8'(i), 0, 0);
    step(0, 1, 8'hFF, 1, 0);
    check("wr_rd_full_num", a_num, 5'd15);
    check("wr_rd_full_ovf", a_ovf, 1'b1);
    step(0, 0, 8'h00, 0, 1);
    check("clr_ovf", a_ovf, 1'b0);
    check("clr_unf", a_unf, 1'b0);

    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
    check("pre_rst_num", a_num, 5'd9);
    step(1, 1, 8'h77, 0, 0);
    check("rst_num", a_num, 5'd0);
    check("rst_dout", a_q, 8'h00);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check("post_rst_word", a_q, 8'h3C);
    step(0, 0, 8'h00, 0, 0);

    b_d = 8'hA5; b_w = 1'b1;
    #1;
    check("b_no_bypass", b_v, 1'b0);
    @(posedge clk);
    #1;
    b_w = 1'b0;
    check("b_dout", b_q, 8'hA5);
    check("b_valid", b_v, 1'b1);
    b_r = 1'b1;
    @(posedge clk);
    #1;
    b_r = 1'b0;
    check("b_pop_valid", b_v, 1'b0);
    check("b_pop_empty", b_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vlc_sync_fifo.md
VLC_SYNC_FIFO -- requirements
Module: vlc_sync_fifo

Interface
REQ-001 SHALL provide parameter F_WIDTH, default 32, data word width in bits.
REQ-002 SHALL provide parameter F_PTR_WIDTH, default 10, log2 of depth; depth F_DEPTH = 2**F_PTR_WIDTH.
REQ-003 SHALL provide parameter F_ALMOST_FULL_VALUE, default 1000, almost-full threshold in words.
REQ-004 SHALL provide parameter F_ALMOST_EMPTY_VALUE, default 5, almost-empty threshold in words.
REQ-005 SHALL provide parameter F_FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports as follows: one clock; reset is synchronous and active-high.
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- d_in  in  F_WIDTH  write data
- w_en  in  1  write request
- r_en  in  1  read request (pop in FWFT mode)
- clr_err  in  1  clears sticky error flags
- d_out  out  F_WIDTH  read data
- d_valid  out  1  d_out holds a valid popped/head word
- f_full_flag, f_empty_flag, f_half_full_flag, f_almost_full_flag, f_almost_empty_flag  out  1 each  status
- data_num  out  F_PTR_WIDTH+1  words stored, 0..F_DEPTH
- f_overflow, f_underflow  out  1 each  sticky error flags

Function
REQ-007 SHALL hold F_DEPTH words in one memory array; write and read pointers F_PTR_WIDTH+1 bits, low bits address memory, MSB resolves wrap.
REQ-008 SHALL accept a write iff w_en=1 and f_full_flag=0: store d_in at write pointer, increment pointer modulo 2**(F_PTR_WIDTH+1).
REQ-009 SHALL accept a read iff r_en=1 and f_empty_flag=0: increment read pointer likewise.
REQ-010 SHALL evaluate full/empty on pre-edge state only; simultaneous write at full with read accepts only the read.
REQ-011 SHALL update data_num each cycle: +1 write only, -1 read only, unchanged both or neither.
REQ-012 SHALL drive f_full_flag = (data_num==F_DEPTH), f_empty_flag = (data_num==0), all registered-count derived.
REQ-013 SHALL drive f_half_full_flag = (data_num >= F_DEPTH/2), f_almost_full_flag = (data_num >= F_ALMOST_FULL_VALUE), f_almost_empty_flag = (data_num <= F_ALMOST_EMPTY_VALUE).
REQ-014 F_FWFT=0: accepted read loads d_out with addressed word at next edge; d_valid=1 for exactly that cycle; otherwise d_out holds, d_valid=0.
REQ-015 F_FWFT=1: d_out = word at read pointer and d_valid = !f_empty_flag, same cycle; r_en pops head; no write-to-read bypass (write into empty FIFO visible one cycle later).
REQ-016 SHALL set f_overflow on w_en=1 while f_full_flag=1; set f_underflow on r_en=1 while f_empty_flag=1; both hold until clr_err=1 or reset; set has priority over clr_err same cycle.
REQ-017 Rejected requests SHALL not change pointers, memory, data_num or d_out.

Reset
REQ-018 reset=1 at a clock edge SHALL zero pointers, data_num, d_out, d_valid, f_overflow, f_underflow; f_empty_flag=1, f_almost_empty_flag=1, other flags 0; overrides any w_en/r_en that cycle.
REQ-019 Memory contents SHALL not be reset; reset mid-operation discards all stored words.

Verification (F_PTR_WIDTH=4, F_ALMOST_FULL_VALUE=14, F_ALMOST_EMPTY_VALUE=2 unless noted)
REQ-020 Write 16 words 0x00..0x0F, F_FWFT=0 -> data_num=16, f_full_flag=1, f_almost_full_flag from count 14, f_half_full_flag from count 8; 17th write -> f_overflow=1, data unchanged.
REQ-021 Read 16 from full, F_FWFT=0 -> d_out 0x00..0x0F, each one cycle after r_en, d_valid pulses; extra read -> f_underflow=1, d_out stays 0x0F.
REQ-022 Hold data_num=5, w_en=r_en=1 for 40 cycles (pointers wrap twice) -> data_num stays 5, output order matches input order.
REQ-023 F_FWFT=1: write 0xA5 into empty FIFO -> next cycle d_out=0xA5, d_valid=1; r_en=1 -> d_valid=0 following cycle.
REQ-024 At data_num=16, w_en=r_en=1 -> only read accepted, data_num=15, f_overflow=1; then clr_err=1 -> both error flags 0.
REQ-025 reset=1 with data_num=9 and w_en=1 -> next cycle data_num=0, f_empty_flag=1, d_out=0, d_valid=0, no write stored.
